// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED refresh controller.
// Serializer state encoding, transfer kinds and the column/page window command list.
package oled_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int WIN_LEN   = 6;

  localparam logic [7:0] CMD_SET_COL  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE = 8'h22;

  typedef enum logic [3:0] {
    PWR_WAIT,
    RST_LOW,
    RST_HIGH,
    IDLE,
    CMD,
    WIN,
    FBRD,
    PIX,
    WAITTX
  } state_e;

  // Which producer owns the byte currently in the serializer.
  typedef enum logic [1:0] {
    XF_CMD,
    XF_WIN,
    XF_PIX
  } xfer_e;

  // Full-screen addressing window: columns 0..127, pages 0..7.
  function automatic logic [7:0] win_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_SET_COL;
      3'd1:    return 8'h00;
      3'd2:    return 8'h7F;
      3'd3:    return CMD_SET_PAGE;
      3'd4:    return 8'h00;
      3'd5:    return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_refresh_ctrl_if.sv
// Command, frame-buffer and serializer handshake bundle for oled_refresh_ctrl.
// master = the controller's view, slave = the surrounding command source / memory / serializer.
interface oled_refresh_ctrl_if;
  import oled_pkg::*;

  logic                 cmd_valid;
  logic [7:0]           cmd_data;
  logic                 cmd_ready;
  logic                 fb_rd_en;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [7:0]           fb_rd_data;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_dc;
  logic                 tx_busy;

  modport master (
    input  cmd_valid, cmd_data, fb_rd_data, tx_busy,
    output cmd_ready, fb_rd_en, fb_addr, tx_start, tx_byte, tx_dc
  );

  modport slave (
    output cmd_valid, cmd_data, fb_rd_data, tx_busy,
    input  cmd_ready, fb_rd_en, fb_addr, tx_start, tx_byte, tx_dc
  );

endinterface

// File: rtl/oled_refresh_timer.sv
// Free-running refresh tick generator with a collapsing pending flag.
// Build option OLED_DIRTY_EN gates ticks with a sticky frame-buffer dirty flag.
module oled_refresh_timer #(
  parameter int REFRESH_PERIOD = 900_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic frame_start,
`ifdef OLED_DIRTY_EN
  input  logic fb_dirty,
`endif
  output logic pending
);

  localparam int            CW   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          arm;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end

`ifdef OLED_DIRTY_EN
  logic dirty;

  // A dirty pulse coinciding with frame start must survive into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dirty <= 1'b0;
    else        dirty <= fb_dirty | (dirty & ~frame_start);
  end

  assign arm = tick & dirty;
`else
  assign arm = tick;
`endif

  // Repeated ticks collapse into one request; a tick on the frame-start cycle re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= arm | (pending & ~frame_start);
  end

endmodule

// File: rtl/oled_refresh_ctrl.sv
// Power-up sequencer and command/refresh arbiter in front of the OLED SPI byte serializer.
// Build option OLED_DIRTY_EN adds fb_dirty: refreshes only run after the frame buffer changed.
module oled_refresh_ctrl
  import oled_pkg::*;
#(
  parameter int STARTUP_WAIT   = 10_000_000,
  parameter int REFRESH_PERIOD = 900_000,
  parameter int FRAME_BYTES    = 1024,
  parameter int CMD_BURST_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  oled_refresh_ctrl_if.master bus,
`ifdef OLED_DIRTY_EN
  input  logic                fb_dirty,
`endif
  output logic                io_reset,
  output logic                io_cs,
  output logic                ready,
  output logic                frame_done
);

  localparam int                   BW        = $clog2(CMD_BURST_MAX + 1);
  localparam logic [BW-1:0]        BURST_MAX = BW'(CMD_BURST_MAX);
  localparam logic [31:0]          LAST_WAIT = 32'(STARTUP_WAIT - 1);
  localparam logic [FB_ADDR_W-1:0] LAST_PIX  = FB_ADDR_W'(FRAME_BYTES - 1);
  localparam logic [2:0]           LAST_WIN  = 3'(WIN_LEN - 1);

  state_e               state_q, state_d;
  xfer_e                xfer_q, xfer_d;
  logic [31:0]          pwr_q, pwr_d;
  logic [2:0]           win_q, win_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 dc_q, dc_d;
  logic                 start_q, start_d;
  logic                 cs_q, cs_d;
  logic                 saw_q, saw_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 cmd_acc;
  logic                 frame_start;
  logic                 pending;

  oled_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (ready_q),
    .frame_start (frame_start),
`ifdef OLED_DIRTY_EN
    .fb_dirty    (fb_dirty),
`endif
    .pending     (pending)
  );

  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    pwr_d       = pwr_q;
    win_d       = win_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    dc_d        = dc_q;
    start_d     = 1'b0;
    cs_d        = cs_q;
    saw_d       = saw_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    cmd_acc     = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      PWR_WAIT, RST_LOW, RST_HIGH: begin
        if (pwr_q == LAST_WAIT) begin
          pwr_d = '0;
          case (state_q)
            PWR_WAIT: state_d = RST_LOW;
            RST_LOW:  state_d = RST_HIGH;
            default: begin
              state_d = IDLE;
              ready_d = 1'b1;
            end
          endcase
        end else begin
          pwr_d = pwr_q + 32'd1;
        end
      end

      IDLE: begin
        // Burst budget only counts commands issued while a refresh is waiting.
        if (!pending) burst_d = '0;
        if (!bus.tx_busy) begin
          if (bus.cmd_valid && (!pending || burst_q < BURST_MAX)) begin
            cmd_acc = 1'b1;
            byte_d  = bus.cmd_data;
            if (pending) burst_d = burst_q + 1'b1;
            state_d = CMD;
          end else if (pending) begin
            burst_d     = '0;
            frame_start = 1'b1;
            win_d       = '0;
            state_d     = WIN;
          end
        end
      end

      CMD: begin
        cs_d    = 1'b0;
        dc_d    = 1'b0;
        start_d = 1'b1;
        saw_d   = 1'b0;
        xfer_d  = XF_CMD;
        state_d = WAITTX;
      end

      WIN: begin
        cs_d    = 1'b0;
        dc_d    = 1'b0;
        byte_d  = win_byte(win_q);
        start_d = 1'b1;
        saw_d   = 1'b0;
        xfer_d  = XF_WIN;
        state_d = WAITTX;
      end

      FBRD: state_d = PIX;

      PIX: begin
        byte_d  = bus.fb_rd_data;
        dc_d    = 1'b1;
        start_d = 1'b1;
        saw_d   = 1'b0;
        xfer_d  = XF_PIX;
        state_d = WAITTX;
      end

      WAITTX: begin
        // Busy is low on the cycle tx_start is seen, so wait for its rise before its fall.
        if (bus.tx_busy) begin
          saw_d = 1'b1;
        end else if (saw_q) begin
          case (xfer_q)
            XF_CMD: begin
              cs_d    = 1'b1;
              state_d = IDLE;
            end
            XF_WIN: begin
              if (win_q == LAST_WIN) begin
                win_d   = '0;
                state_d = FBRD;
              end else begin
                win_d   = win_q + 3'd1;
                state_d = WIN;
              end
            end
            default: begin
              if (addr_q == LAST_PIX) begin
                addr_d  = '0;
                done_d  = 1'b1;
                cs_d    = 1'b1;
                state_d = IDLE;
              end else begin
                addr_d  = addr_q + 1'b1;
                state_d = FBRD;
              end
            end
          endcase
        end
      end

      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      xfer_q  <= XF_CMD;
      pwr_q   <= '0;
      win_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      dc_q    <= 1'b0;
      start_q <= 1'b0;
      cs_q    <= 1'b1;
      saw_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      pwr_q   <= pwr_d;
      win_q   <= win_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      dc_q    <= dc_d;
      start_q <= start_d;
      cs_q    <= cs_d;
      saw_q   <= saw_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_acc;
  assign bus.fb_rd_en  = (state_q == FBRD);
  assign bus.fb_addr   = addr_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_byte   = byte_q;
  assign bus.tx_dc     = dc_q;
  assign io_reset      = (state_q != RST_LOW);
  assign io_cs         = cs_q;
  assign ready         = ready_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_oled_refresh_ctrl.sv
// Scoreboard bench for oled_refresh_ctrl: power-up, commands, frames, starvation, collapse, mid-frame reset.
// Serializer and frame-buffer models are behavioural; expected SPI bytes live in exp_q.
module tb_oled_refresh_ctrl;

  localparam int SW       = 4;
  localparam int PER      = 1000;
  localparam int FB       = 8;
  localparam int BURST    = 4;
  localparam int BUSY_CYC = 3;

  logic clk;
  logic rst_n;
  logic io_reset, io_cs, ready, frame_done;
  logic force_busy;
  int   ser_cnt;
  int   cyc;
  int   r0;

  int   n_vec, n_miss;
  int   n_start, n_pre, n_crdy, n_done, n_csr;
  logic cs_prev;

  logic [8:0] exp_q[$];
  logic [7:0] winb [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  oled_refresh_ctrl_if bus ();

  oled_refresh_ctrl #(
    .STARTUP_WAIT   (SW),
    .REFRESH_PERIOD (PER),
    .FRAME_BYTES    (FB),
    .CMD_BURST_MAX  (BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
`ifdef OLED_DIRTY_EN
    .fb_dirty   (1'b1),
`endif
    .io_reset   (io_reset),
    .io_cs      (io_cs),
    .ready      (ready),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer: busy from the cycle after tx_start for BUSY_CYC cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ser_cnt <= 0;
    else if (bus.tx_start) ser_cnt <= BUSY_CYC;
    else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
  end
  assign bus.tx_busy = (ser_cnt != 0) || force_busy;

  // Frame buffer holds its own address as contents.
  always @(posedge clk) if (bus.fb_rd_en) bus.fb_rd_data <= 8'(bus.fb_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        n_start++;
        if (!ready) n_pre++;
        chk("start_busy", 32'(bus.tx_busy), 0);
        chk("start_cs", 32'(io_cs), 0);
        if (exp_q.size() != 0) chk("tx_byte", {bus.tx_dc, bus.tx_byte}, exp_q.pop_front());
        else                   chk("tx_extra", {bus.tx_dc, bus.tx_byte}, 9'h1FF);
      end
      if (bus.cmd_ready)        n_crdy++;
      if (frame_done)           n_done++;
      if (io_cs && !cs_prev)    n_csr++;
    end
    cs_prev = io_cs;
  end

  task automatic chk_rst(input string tag);
    chk(tag, {io_reset, io_cs, ready, frame_done, bus.tx_start, bus.tx_dc, bus.cmd_ready,
              bus.fb_rd_en, bus.fb_addr, bus.tx_byte}, {8'b1100_0000, 10'd0, 8'd0});
  endtask

  task automatic wait_until(input int t);
    do begin
      @(posedge clk); #1;
    end while (cyc < t);
  endtask

  task automatic power_up();
    int pre0;
    pre0 = n_pre;
    @(negedge clk);
    chk_rst("rst_vals");
    rst_n = 1'b1;
    chk("pwr_0", {io_reset, ready}, 2'b10);
    for (int n = 1; n <= 3 * SW; n++) begin
      @(posedge clk); #1;
      chk($sformatf("pwr_%0d", n), {io_reset, ready},
          {!(n >= SW && n < 2 * SW), (n >= 3 * SW)});
    end
    r0 = cyc;
    chk("pre_ready_start", n_pre - pre0, 0);
  endtask

  task automatic exp_frame(input int npix);
    for (int i = 0; i < 6; i++)    exp_q.push_back({1'b0, winb[i]});
    for (int i = 0; i < npix; i++) exp_q.push_back({1'b1, 8'(i)});
  endtask

  task automatic send_cmds(input logic [7:0] b0, input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      hs = 1'b0;
      bus.cmd_data  = b0 + 8'(i);
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 400 && !hs; k++) begin
        @(negedge clk);
        hs = bus.cmd_ready;
      end
      chk("cmd_hs", 32'(hs), 1);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int s0, d0, c0, k0;
    bit hit;
    n_vec = 0; n_miss = 0;
    n_start = 0; n_pre = 0; n_crdy = 0; n_done = 0; n_csr = 0;
    cs_prev = 1'b1; cyc = 0;
    rst_n = 1'b0; force_busy = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00;

    repeat (3) @(posedge clk);
    power_up();

    // Single command with no refresh pending.
    wait_until(r0 + 50);
    c0 = n_crdy; k0 = n_csr;
    exp_q.push_back({1'b0, 8'hAF});
    send_cmds(8'hAF, 1);
    wait_until(r0 + 100);
    chk("cmd_ready_cnt", n_crdy - c0, 1);
    chk("cmd_cs_rise", n_csr - k0, 1);
    chk("cmd_cs_idle", 32'(io_cs), 1);

    // First refresh frame.
    wait_until(r0 + 900);
    s0 = n_start; d0 = n_done; k0 = n_csr;
    exp_frame(FB);
    wait_until(r0 + 1200);
    chk("frm_starts", n_start - s0, 14);
    chk("frm_done", n_done - d0, 1);
    chk("frm_cs_rise", n_csr - k0, 1);
    chk("frm_addr_wrap", 32'(bus.fb_addr), 0);

    // Starvation: refresh pending while commands stream in.
    wait_until(r0 + 1990);
    force_busy = 1'b1;
    c0 = n_crdy; d0 = n_done;
    for (int i = 0; i < BURST; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
    exp_frame(FB);
    for (int i = BURST; i < 8; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
    wait_until(r0 + 2005);
    fork
      send_cmds(8'h40, 8);
      begin
        wait_until(r0 + 2015);
        force_busy = 1'b0;
      end
    join
    wait_until(r0 + 2300);
    chk("starve_cmds", n_crdy - c0, 8);
    chk("starve_frames", n_done - d0, 1);

    // Regular frame, then hold the serializer busy across two ticks.
    wait_until(r0 + 2900);
    exp_frame(FB);
    wait_until(r0 + 3200);
    force_busy = 1'b1;
    wait_until(r0 + 5500);
    d0 = n_done;
    exp_frame(FB);
    force_busy = 1'b0;
    wait_until(r0 + 5950);
    chk("collapse_frames", n_done - d0, 1);

    // Reset in the middle of pixel 3.
    exp_frame(4);
    hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      @(negedge clk);
      hit = bus.tx_start && bus.tx_dc && (bus.tx_byte == 8'h03);
    end
    chk("pix3_seen", 32'(hit), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_rst("rst_async");
    repeat (3) @(posedge clk);
    power_up();
    s0 = n_start;
    wait_until(r0 + 100);
    chk("post_rst_quiet", n_start - s0, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
